// File: rtl/l2_scrub_pkg.sv
// Shared types and helpers for the L2 bank scrubber: state encoding, mode bit
// positions and the expected-word function used for both fill and check.
package l2_scrub_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int MODE_WR   = 0;
  localparam int MODE_CHK  = 1;
  localparam int MODE_AXOR = 2;

  // Wide enough for any practical bank; callers zero-extend in and truncate out.
  localparam int EXP_W = 64;

  function automatic logic [EXP_W-1:0] exp(input logic [EXP_W-1:0] pattern,
                                           input logic [EXP_W-1:0] addr,
                                           input logic             axor);
    return pattern ^ (axor ? addr : {EXP_W{1'b0}});
  endfunction

endpackage

// File: rtl/l2_scrub_checker.sv
// Read-back checker: carries the expected word and address of a granted read
// one cycle forward, compares against returned data and keeps error status.
module l2_scrub_checker
  import l2_scrub_pkg::*;
#(
  parameter int ADDR_WIDTH    = 14,
  parameter int DATA_WIDTH    = 32,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     vld,
  input  logic [DATA_WIDTH-1:0]    expected,
  input  logic [ADDR_WIDTH-1:0]    addr,
  input  logic [DATA_WIDTH-1:0]    rdata,
  output logic                     pending,
  output logic                     err,
  output logic [ADDR_WIDTH-1:0]    err_addr,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] exp_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic                  mismatch;

  assign pending  = vld_p1;
  assign mismatch = vld_p1 && (rdata != exp_p1);

  // p0 -> p1: capture expected word and address alongside the read request
  always_ff @(posedge clk) begin
    if (vld) begin
      exp_p1  <= expected;
      addr_p1 <= addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      err      <= 1'b0;
      err_addr <= '0;
      err_cnt  <= '0;
    end else begin
      vld_p1 <= vld;
      if (clear) begin
        err      <= 1'b0;
        err_addr <= '0;
        err_cnt  <= '0;
      end else if (mismatch) begin
        err <= 1'b1;
        if (!err) err_addr <= addr_p1;
        if (err_cnt != {ERR_CNT_WIDTH{1'b1}}) err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/l2_bank_scrubber.sv
// L2 bank scrubber: walks [base, last] on the bank SRAM port, optionally
// filling with a pattern and optionally reading back and comparing.
module l2_bank_scrubber
  import l2_scrub_pkg::*;
#(
  parameter int ADDR_WIDTH    = 14,
  parameter int DATA_WIDTH    = 32,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic [2:0]                mode_i,
  input  logic [DATA_WIDTH-1:0]     pattern_i,
  input  logic [ADDR_WIDTH-1:0]     base_addr_i,
  input  logic [ADDR_WIDTH-1:0]     last_addr_i,
  input  logic                      gnt_i,
  output logic                      mem_csn_o,
  output logic                      mem_wen_o,
  output logic [DATA_WIDTH/8-1:0]   mem_be_o,
  output logic [ADDR_WIDTH-1:0]     mem_add_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      aborted_o,
  output logic                      err_o,
  output logic [ADDR_WIDTH-1:0]     err_addr_o,
  output logic [ERR_CNT_WIDTH-1:0]  err_cnt_o
);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cur, cur_nxt, base_q, last_q;
  logic [2:0]            mode_q;
  logic [DATA_WIDTH-1:0] pattern_q, exp_word;
  logic                  start_ok, req, wr_req, rd_fire, abort_set, chk_pending, aborted;

  assign start_ok = (state == ST_IDLE) && start_i;
  assign exp_word = DATA_WIDTH'(exp(EXP_W'(pattern_q), EXP_W'(cur), mode_q[MODE_AXOR]));

  // Abort suppresses the request in the very cycle it is seen.
  assign req     = ((state == ST_WRITE) || (state == ST_READ)) && !abort_i;
  assign wr_req  = req && (state == ST_WRITE);
  assign rd_fire = req && (state == ST_READ) && gnt_i;

  assign mem_csn_o   = !req;
  assign mem_wen_o   = !wr_req;
  assign mem_be_o    = req ? '1 : '0;
  assign mem_add_o   = req ? cur : '0;
  assign mem_wdata_o = wr_req ? exp_word : '0;
  assign busy_o      = (state != ST_IDLE);
  assign done_o      = (state == ST_DONE);
  assign aborted_o   = aborted;

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    abort_set = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          cur_nxt = base_addr_i;
          if ((last_addr_i < base_addr_i) || (mode_i[1:0] == 2'b00)) state_nxt = ST_DONE;
          else if (mode_i[MODE_WR])                                   state_nxt = ST_WRITE;
          else                                                        state_nxt = ST_READ;
        end
      end
      ST_WRITE: begin
        if (abort_i) begin
          abort_set = 1'b1;
          state_nxt = ST_DONE;
        end else if (gnt_i) begin
          if (cur == last_q) begin
            cur_nxt   = base_q;
            state_nxt = mode_q[MODE_CHK] ? ST_READ : ST_DONE;
          end else begin
            cur_nxt = cur + ADDR_WIDTH'(1);
          end
        end
      end
      ST_READ: begin
        // Termination compares against last, so a range ending at the top
        // address never relies on the counter overflowing.
        if (abort_i) begin
          abort_set = 1'b1;
          state_nxt = chk_pending ? ST_DRAIN : ST_DONE;
        end else if (gnt_i) begin
          if (cur == last_q) state_nxt = ST_DRAIN;
          else               cur_nxt   = cur + ADDR_WIDTH'(1);
        end
      end
      ST_DRAIN: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      aborted <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_ok)       aborted <= 1'b0;
      else if (abort_set) aborted <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    cur <= cur_nxt;
    if (start_ok) begin
      mode_q    <= mode_i;
      pattern_q <= pattern_i;
      base_q    <= base_addr_i;
      last_q    <= last_addr_i;
    end
  end

  l2_scrub_checker #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .ERR_CNT_WIDTH(ERR_CNT_WIDTH)
  ) u_checker (
    .clk      (clk_i),
    .rst      (rst_i),
    .clear    (start_ok),
    .vld      (rd_fire),
    .expected (exp_word),
    .addr     (cur),
    .rdata    (mem_rdata_i),
    .pending  (chk_pending),
    .err      (err_o),
    .err_addr (err_addr_o),
    .err_cnt  (err_cnt_o)
  );

endmodule

// File: doc/l2_bank_scrubber.md
Name: l2_bank_scrubber

Overview:
- Initiator on the L2 bank SRAM bus (csn/wen/be/add/wdata/rdata, active-low csn/wen, 1-cycle read latency).
- Walks an address range of one L2 bank, optionally filling it with a pattern and optionally reading it back and comparing.
- Used for boot-time memory init, scrubbing and production self-check.
- Sits in front of a bank via the existing bank port mux; a grant input lets functional traffic take priority.

Parameters:
- ADDR_WIDTH, 14, bank word-address width.
- DATA_WIDTH, 32, data width; BE width = DATA_WIDTH/8.
- ERR_CNT_WIDTH, 16, error counter width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- start_i  in  1  start pulse; sampled in IDLE only.
- abort_i  in  1  stop at next access boundary.
- mode_i  in  3  bit0 = write phase, bit1 = check phase, bit2 = XOR word address into the pattern.
- pattern_i  in  DATA_WIDTH  fill/expected base pattern.
- base_addr_i  in  ADDR_WIDTH  first word address.
- last_addr_i  in  ADDR_WIDTH  last word address, inclusive.
- gnt_i  in  1  bus granted this cycle.
- mem_csn_o  out  1  chip select, active-low.
- mem_wen_o  out  1  write enable, active-low.
- mem_be_o  out  DATA_WIDTH/8  byte enables, active-high; always all ones when accessing.
- mem_add_o  out  ADDR_WIDTH  word address.
- mem_wdata_o  out  DATA_WIDTH  write data.
- mem_rdata_i  in  DATA_WIDTH  read data, valid one cycle after a granted read.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse in DONE.
- aborted_o  out  1  sticky; run ended by abort.
- err_o  out  1  sticky; at least one mismatch.
- err_addr_o  out  ADDR_WIDTH  address of the first mismatch.
- err_cnt_o  out  ERR_CNT_WIDTH  mismatch count; saturates at all ones.

Behaviour:
- Reset: state IDLE.
  - mem_csn_o=1, mem_wen_o=1, mem_be_o=0, mem_add_o=0, mem_wdata_o=0.
  - All status outputs 0.
- Accepted start (IDLE & start_i):
  - Latches mode, pattern, base and last.
  - Clears err_o, err_addr_o, err_cnt_o and aborted_o.
  - start_i outside IDLE is ignored.
- Expected data: exp(a) = pattern ^ (mode[2] ? zero-extended a : 0).
- States: IDLE, WRITE, READ, DRAIN, DONE. Transitions from the start cycle:
  - Empty range (last < base) or mode[1:0]=00 -> DONE; no accesses.
  - Otherwise mode[0] -> WRITE, else READ.
- WRITE:
  - Drives csn=0, wen=0, add=cur, wdata=exp(cur).
  - An access completes only in a cycle with gnt_i=1; cur then advances by 1.
  - With gnt_i=0, outputs still present the request and cur holds.
  - After the access at last completes: mode[1] -> READ with cur=base; else -> DONE.
- READ:
  - Drives csn=0, wen=1, add=cur; advances on gnt_i as in WRITE.
  - Each granted read sets a pending flag plus a pipelined expected value and address.
  - In the next cycle, mem_rdata_i is compared against them, regardless of gnt_i in that cycle.
  - After the granted read at last -> DRAIN.
- DRAIN:
  - csn=1.
  - The final pending compare completes.
  - Then -> DONE.
- DONE:
  - done_o=1 for exactly one cycle.
  - Then -> IDLE; status holds until the next accepted start.
- Mismatch handling:
  - err_o set.
  - err_cnt_o increments, saturating.
  - err_addr_o loads only on the first mismatch of the run.
- abort_i high in WRITE or READ:
  - No new request is issued.
  - Any pending compare still completes (through DRAIN if pending).
  - aborted_o set; -> DONE.
- Wrap-around: cur never wraps. last = 2^ADDR_WIDTH-1 is legal; termination uses equality to last, not overflow.
- Reset mid-run: immediate return to IDLE with outputs at reset values; the pending compare is discarded.
- Latency with gnt_i held at 1 and N = last-base+1 (start sampled in cycle 0):
  - Fill-only: accesses in cycles 1..N, done_o in cycle N+1.
  - Check-only: reads in 1..N, DRAIN at N+1, done_o at N+2.
  - Fill+check: done_o at 2N+2.

Decomposition:
- Package l2_scrub_pkg:
  - state enum (IDLE/WRITE/READ/DRAIN/DONE).
  - mode bit index constants (MODE_WR=0, MODE_CHK=1, MODE_AXOR=2).
  - expected-data function exp(pattern, addr, axor).
- Sub-module l2_scrub_checker:
  - pending/expected pipeline register, comparator, sticky error flag, first-address capture, saturating counter.
  - Inputs: valid, expected, address, rdata, clear.

Test Plan:
- Fill+check, base=0x10, last=0x13, pattern=0xA5A5A5A5, mode=011, gnt=1, ideal model -> 4 writes then 4 reads at 0x10..0x13; done_o in cycle 10; err_o=0, err_cnt_o=0.
- Check-only, mode=110, model word 0x12 corrupted to 0x0 with pattern=0xFFFF0000 -> err_o=1, err_addr_o=0x12, err_cnt_o=1; other words read back 0xFFFF0000^addr.
- gnt_i low for 3 cycles mid-fill at cur=0x11 -> mem_add_o holds 0x11 during the stall, no address skipped or repeated, done_o delayed by exactly 3 cycles.
- abort_i pulsed in cycle after first granted read (range 0..7, mode=010) -> no further csn=0, one compare completes, aborted_o=1, done_o within 2 cycles.
- last_addr_i=0x3 < base_addr_i=0x5 -> no csn=0 ever, done_o in cycle 1, all error status 0.
- All 8 words mismatching with ERR_CNT_WIDTH=2 -> err_cnt_o saturates at 3, err_addr_o = first address. rst_i asserted mid-READ -> next cycle IDLE, csn=1, busy_o=0.
